// File: rtl/matmul_8x8_c_writer.sv
// Output-drain stage for the 8x8 fp16 systolic matmul: buffers result beats in a
// small FIFO and serialises each beat into two C-memory writes from a base address.
module matmul_8x8_c_writer #(
  parameter int DWIDTH          = 16,
  parameter int BB_MAT_MUL_SIZE = 4,
  parameter int AWIDTH          = 7,
  parameter int NUM_BEATS       = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [AWIDTH-1:0]                 c_base_addr,
  input  logic                              c_valid,
  output logic                              c_ready,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_row_0,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_row_1,
  output logic                              c_wr_en,
  output logic [AWIDTH-1:0]                 c_wr_addr,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_wr_data,
  output logic                              busy,
  output logic                              done,
  output logic                              protocol_err
);

  localparam int RW  = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(NUM_BEATS + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WR0,
    WR1,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [2*RW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [FCW-1:0]  fifo_count;
  logic [CW-1:0]   in_cnt, out_cnt;
  logic [AWIDTH-1:0] base;
  logic            push, pop;
  logic [2*RW-1:0] head, next_head;

  assign busy    = (state == ARMED) || (state == WR0) || (state == WR1);
  assign done    = (state == FINISH);
  assign c_ready = busy && (fifo_count < FCW'(FIFO_DEPTH)) && (in_cnt < CW'(NUM_BEATS));
  assign push    = c_valid && c_ready;
  assign pop     = (state == WR1);
  assign head    = fifo_mem[rd_ptr];

  // Head of the FIFO after this cycle's pop; may be the beat being pushed right now.
  assign next_head = (fifo_count > FCW'(1)) ? fifo_mem[rd_ptr + PW'(1)]
                                            : {c_data_row_1, c_data_row_0};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {c_data_row_1, c_data_row_0};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = ARMED;
      ARMED:  if (fifo_count != '0) state_next = WR0;
      WR0:    state_next = WR1;
      WR1: begin
        if ((fifo_count > FCW'(1)) || push) begin
          state_next = WR0;
        end else if ((out_cnt + CW'(1)) < CW'(NUM_BEATS)) begin
          state_next = ARMED;
        end else begin
          state_next = FINISH;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      base         <= '0;
      protocol_err <= 1'b0;
      c_wr_en      <= 1'b0;
      c_wr_addr    <= '0;
      c_wr_data    <= '0;
    end else begin
      state <= state_next;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCW'(1);
        2'b01:   fifo_count <= fifo_count - FCW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if ((state == IDLE) && start) begin
        base    <= c_base_addr;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (push) in_cnt  <= in_cnt + CW'(1);
        if (pop)  out_cnt <= out_cnt + CW'(1);
      end

      if (c_valid && !busy) protocol_err <= 1'b1;

      // Write port is loaded from the upcoming state so it lines up with WR0/WR1.
      c_wr_en <= (state_next == WR0) || (state_next == WR1);
      if (state_next == WR0) begin
        if (state == WR1) begin
          c_wr_addr <= base + AWIDTH'(out_cnt + CW'(1));
          c_wr_data <= next_head[RW-1:0];
        end else begin
          c_wr_addr <= base + AWIDTH'(out_cnt);
          c_wr_data <= head[RW-1:0];
        end
      end else if (state_next == WR1) begin
        c_wr_addr <= base + AWIDTH'(NUM_BEATS) + AWIDTH'(out_cnt);
        c_wr_data <= head[2*RW-1:RW];
      end
    end
  end

endmodule

// File: tb/tb_matmul_8x8_c_writer.sv
// Directed bench for matmul_8x8_c_writer: a scoreboard of expected writes is filled
// as beats are accepted and drained by a write monitor.
module tb_matmul_8x8_c_writer;

  localparam int AW = 7;
  localparam int NB = 8;
  localparam int RW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] c_base_addr = '0;
  logic          c_valid = 1'b0;
  logic [RW-1:0] c_data_row_0 = '0;
  logic [RW-1:0] c_data_row_1 = '0;
  logic          c_ready, c_wr_en, busy, done, protocol_err;
  logic [AW-1:0] c_wr_addr;
  logic [RW-1:0] c_wr_data;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  logic [AW-1:0] model_base = '0;
  int            assertions = 0;
  int            failures = 0;
  int            cyc = 0;
  int            done_count = 0;
  int            done_cyc = 0;
  int            wr_count = 0;
  int            first_wr_cyc = 0;
  int            last_wr_cyc = 0;
  int            acc_cyc0 = 0;
  bit            ready_low_seen = 1'b0;

  matmul_8x8_c_writer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .c_base_addr  (c_base_addr),
    .c_valid      (c_valid),
    .c_ready      (c_ready),
    .c_data_row_0 (c_data_row_0),
    .c_data_row_1 (c_data_row_1),
    .c_wr_en      (c_wr_en),
    .c_wr_addr    (c_wr_addr),
    .c_wr_data    (c_wr_data),
    .busy         (busy),
    .done         (done),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin : monitor
    wr_t exp_wr;
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (reset && c_wr_en) begin
      if (wr_count == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        exp_wr = sb.pop_front();
        checkOutput("wr_addr", 64'(c_wr_addr), 64'(exp_wr.addr));
        checkOutput("wr_data", c_wr_data, exp_wr.data);
      end
    end
  end

  task automatic applyStimulus(input int k, input int gap, input int tag);
    logic [RW-1:0] r0, r1;
    bit accepted;
    r0 = {32'(tag), 32'(k)};
    r1 = {32'(tag), 32'(256 + k)};
    c_valid = 1'b1;
    c_data_row_0 = r0;
    c_data_row_1 = r1;
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      if (c_ready) begin
        if (k == 0) acc_cyc0 = cyc;
        sb.push_back('{addr: AW'(model_base + AW'(k)), data: r0});
        sb.push_back('{addr: AW'(model_base + AW'(NB) + AW'(k)), data: r1});
        accepted = 1'b1;
      end else begin
        ready_low_seen = 1'b1;
      end
      @(negedge clk);
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    if (gap > 0) begin
      c_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic runMatrix(input logic [AW-1:0] base, input int gap, input int tag,
                           input bit restart_mid, input bit try_ninth, input bit back_to_back);
    int d0;
    bit seen;
    start = 1'b1;
    c_base_addr = base;
    @(negedge clk);
    start = 1'b0;
    c_base_addr = 7'h55;
    model_base = base;
    wr_count = 0;
    ready_low_seen = 1'b0;
    d0 = done_count;
    for (int k = 0; k < NB; k++) begin
      applyStimulus(k, gap, tag);
      if (restart_mid && k == 1) begin
        c_valid = 1'b0;
        start = 1'b1;
        c_base_addr = 7'h40;
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (try_ninth) begin
      c_data_row_0 = 64'hDEAD;
      c_data_row_1 = 64'hBEEF;
      seen = 1'b0;
      repeat (4) begin
        if (c_ready) seen = 1'b1;
        @(negedge clk);
      end
      checkOutput($sformatf("t%0d_ninth_beat_ready", tag), 64'(seen), 0);
      checkOutput($sformatf("t%0d_ready_dropped", tag), 64'(ready_low_seen), 1);
    end
    c_valid = 1'b0;
    for (int i = 0; i < 300 && done_count == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput($sformatf("t%0d_done_count", tag), 64'(done_count - d0), 1);
    checkOutput($sformatf("t%0d_busy_after", tag), 64'(busy), 0);
    checkOutput($sformatf("t%0d_write_count", tag), 64'(wr_count), 16);
    checkOutput($sformatf("t%0d_sb_empty", tag), 64'(sb.size()), 0);
    checkOutput($sformatf("t%0d_first_latency", tag), 64'(first_wr_cyc - acc_cyc0), 2);
    checkOutput($sformatf("t%0d_done_after_last", tag), 64'(done_cyc - last_wr_cyc), 1);
    if (back_to_back)
      checkOutput($sformatf("t%0d_write_span", tag), 64'(last_wr_cyc - first_wr_cyc), 15);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    $display("[TB] starting matmul_8x8_c_writer bench");
    repeat (3) @(negedge clk);
    checkOutput("reset_wr_en", 64'(c_wr_en), 0);
    checkOutput("reset_wr_addr", 64'(c_wr_addr), 0);
    checkOutput("reset_wr_data", c_wr_data, 0);
    checkOutput("reset_busy", 64'(busy), 0);
    checkOutput("reset_done", 64'(done), 0);
    checkOutput("reset_ready", 64'(c_ready), 0);
    checkOutput("reset_perr", 64'(protocol_err), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    runMatrix(7'h10, 0, 1, 1'b0, 1'b0, 1'b1);
    runMatrix(7'h00, 0, 2, 1'b0, 1'b1, 1'b1);
    runMatrix(7'h7C, 0, 3, 1'b0, 1'b0, 1'b1);
    runMatrix(7'h08, 4, 4, 1'b0, 1'b0, 1'b0);
    checkOutput("perr_clean_so_far", 64'(protocol_err), 0);

    c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    checkOutput("perr_set", 64'(protocol_err), 1);
    checkOutput("perr_idle_ready", 64'(c_ready), 0);
    runMatrix(7'h20, 1, 5, 1'b1, 1'b0, 1'b0);
    checkOutput("perr_sticky", 64'(protocol_err), 1);

    // Abort a matrix after three beats with a one-edge reset.
    start = 1'b1;
    c_base_addr = 7'h30;
    @(negedge clk);
    start = 1'b0;
    model_base = 7'h30;
    for (int k = 0; k < 3; k++) applyStimulus(k, 0, 6);
    c_valid = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk);
    sb.delete();
    d0 = done_count;
    @(negedge clk);
    checkOutput("midrst_wr_en", 64'(c_wr_en), 0);
    checkOutput("midrst_wr_addr", 64'(c_wr_addr), 0);
    checkOutput("midrst_wr_data", c_wr_data, 0);
    checkOutput("midrst_busy", 64'(busy), 0);
    checkOutput("midrst_done", 64'(done), 0);
    checkOutput("midrst_perr", 64'(protocol_err), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midrst_no_done", 64'(done_count - d0), 0);
    checkOutput("midrst_no_write", 64'(c_wr_en), 0);
    runMatrix(7'h30, 0, 7, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/matmul_8x8_c_writer.md
# matmul_8x8_c_writer

Output-drain stage placed directly downstream of the 8x8 fp16 systolic matmul. It accepts beats carrying the two 4-element result row-vectors (`c_data_row_0`, `c_data_row_1`) and buffers them in a small FIFO. It then serialises each beat into two single-port writes to the C result memory, generating addresses from a programmable base. It reports completion after `NUM_BEATS` beats have been written.

## Interface
- `DWIDTH`, 16: fp16 element width (sign 1, exponent 5, mantissa 10); data is opaque to this block.
- `BB_MAT_MUL_SIZE`, 4: elements per row-vector.
- `AWIDTH`, 7: C memory address width.
- `NUM_BEATS`, 8: beats per matrix.
- `FIFO_DEPTH`, 4: beat FIFO entries; power of two, at least 2.

Ports:
- `clk`, in, 1: clock; all logic is rising-edge.
- `reset`, in, 1: one clock; reset is synchronous and active-low (`reset==0` resets on the clock edge).
- `start`, in, 1: single-cycle pulse; arms the block for one matrix.
- `c_base_addr`, in, AWIDTH: base address; sampled on `start`.
- `c_valid`, in, 1: beat valid.
- `c_ready`, out, 1: beat accept; a transfer happens when `c_valid & c_ready` at a clock edge.
- `c_data_row_0`, in, BB_MAT_MUL_SIZE*DWIDTH: upper block-row vector.
- `c_data_row_1`, in, BB_MAT_MUL_SIZE*DWIDTH: lower block-row vector.
- `c_wr_en`, out, 1: memory write strobe.
- `c_wr_addr`, out, AWIDTH: write address.
- `c_wr_data`, out, BB_MAT_MUL_SIZE*DWIDTH: write data.
- `busy`, out, 1: armed or draining.
- `done`, out, 1: one-cycle completion pulse.
- `protocol_err`, out, 1: sticky; set when `c_valid` is high while not armed.

## Operation
**Reset.** All outputs are 0, the FIFO is empty, all counters are 0, and the FSM is in IDLE.

**Start.**
- `start` in IDLE latches `c_base_addr`, clears `in_cnt`/`out_cnt`, and sets `busy`.
- `start` while `busy` is ignored.
- `protocol_err` is cleared only by reset.

**Input side.**
- `c_ready = busy & (fifo_count < FIFO_DEPTH) & (in_cnt < NUM_BEATS)`.
- Each accepted beat pushes {row_1, row_0} and increments `in_cnt`.
- `c_valid` while not `busy`: the beat is dropped and `protocol_err` is set.

**FSM.**
- IDLE → ARMED on `start`.
- ARMED → WR0 when the FIFO is non-empty.
- WR0 → WR1 unconditionally.
- WR1 → WR0 if the FIFO still holds a beat after the pop; else → ARMED if `out_cnt < NUM_BEATS`; else → FINISH.
- FINISH → IDLE unconditionally.

**Write outputs.** All write outputs are registered.
- In WR0, beat k (k = `out_cnt`) drives `c_wr_en=1`, `c_wr_addr = base + k`, `c_wr_data = row_0`.
- In WR1, beat k drives `c_wr_en=1`, `c_wr_addr = base + NUM_BEATS + k`, `c_wr_data = row_1`.
- The FIFO pops and `out_cnt` increments at the end of WR1.
- Address arithmetic is modulo 2^AWIDTH; wrap-around is silent.
- `c_wr_en=0` in every other state; `c_wr_addr`/`c_wr_data` hold their last value.

**Completion.**
- FINISH drives `done=1` for exactly one cycle and deasserts `busy` in that same cycle.
- `start` during FINISH is ignored.

**FIFO.** Push and pop on the same edge are allowed; the count is unchanged.

## Timing
- Beat accepted at edge t: its row_0 write is visible in cycle t+1 → t+2 (the WR0 cycle), and its row_1 write in the following cycle.
- Latency is therefore 2 cycles from acceptance to the first write strobe.
- Sustained throughput is 1 beat per 2 cycles with back-to-back WR0/WR1 and no bubbles while the FIFO is non-empty.
- `c_ready` is combinational from registered state only; there is no combinational path from `c_valid`.
- `done` asserts the cycle after the final WR1 cycle.
- Total for `NUM_BEATS=8` with continuous input: the first write is 2 cycles after the first accept, the last write ends 16 cycles later, and `done` follows 1 cycle after that.
- Reset low mid-operation clears everything on that edge: `c_wr_en=0` next cycle, FIFO contents discarded, no `done`.

## Test plan
- **Basic write-out.** Reset; `start` with base=0x10; 8 consecutive beats (row_0=beat index k, row_1=0x100+k) → 16 writes alternating addr 0x10+k / 0x18+k with matching data, exactly one `done`, `busy` low afterwards.
- **Backpressure.** Drive `c_valid` constantly → `c_ready` drops when the FIFO holds 4 beats; no beat is lost or duplicated; ordering is preserved; the 9th beat is never accepted (`in_cnt` caps at 8).
- **Address wrap.** base=0x7C → row_0 addresses 0x7C..0x7F then 0x00..0x03; row_1 addresses 0x04..0x0B.
- **Sparse input.** One beat every 5 cycles → ARMED idles between beats; each beat produces exactly 2 writes, the first 2 cycles after acceptance; `done` only after beat 8.
- **Protocol error and ignored start.** `c_valid` pulse while IDLE → `protocol_err`=1 and stays 1; a second `start` mid-matrix is ignored (base unchanged).
- **Reset mid-operation.** Assert `reset`=0 after 3 beats → next cycle all outputs are 0 and there is no `done`; a following `start` with 8 beats completes normally.
